// File: rtl/awgn_clt_gen.sv
// awgn_clt_gen
// Multi-channel additive white Gaussian noise generator. Each channel runs its
// own xorshift32 uniform source and sums SUM_LEN uniforms (central limit
// theorem) into an approximately Gaussian sample. The sample is then scaled by
// a run-time programmable per-channel gain and saturated symmetrically.
//
// Ports:
//   clock    in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   init     in   reload channel states from seed, flush sum and stage 1
//   ce       in   draw enable, one uniform per channel per ce cycle
//   seed     in   base seed, sampled while init=1
//   gain_we  in   gain write strobe
//   gain_sel in   channel index for the gain write (out-of-range ignored)
//   gain_val in   unsigned gain, GAIN_FRAC fraction bits
//   x_en     out  one-cycle pulse, awgn holds a new sample set
//   awgn     out  channel k in bits [k*OUT_W +: OUT_W], two's complement
module awgn_clt_gen #(
    parameter int          NUM_CH       = 2,
    parameter int          OUT_W        = 16,
    parameter int          U_W          = 12,
    parameter int          SUM_LEN      = 12,
    parameter int          GAIN_W       = 16,
    parameter int          GAIN_FRAC    = 12,
    parameter logic [31:0] SEED_DEFAULT = 32'h1
) (
    input  logic                                         clock,
    input  logic                                         rst_n,
    input  logic                                         init,
    input  logic                                         ce,
    input  logic [31:0]                                  seed,
    input  logic                                         gain_we,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] gain_sel,
    input  logic [GAIN_W-1:0]                            gain_val,
    output logic                                         x_en,
    output logic [NUM_CH*OUT_W-1:0]                      awgn
);

    localparam int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W  = $clog2(SUM_LEN);
    // One extra bit over the unsigned sum range so the centred value is signed.
    localparam int ACC_W  = U_W + $clog2(SUM_LEN) + 1;
    localparam int PROD_W = ACC_W + GAIN_W + 1;

    localparam logic [CNT_W-1:0]         CNT_LAST = CNT_W'(SUM_LEN - 1);
    localparam logic [ACC_W-1:0]         OFFSET   = ACC_W'(SUM_LEN * (2 ** (U_W - 1)));
    localparam logic [GAIN_W-1:0]        GAIN_ONE = GAIN_W'(1 << GAIN_FRAC);
    localparam logic signed [PROD_W-1:0] P_MAX    = PROD_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [PROD_W-1:0] P_MIN    = -P_MAX;

    // Per-channel start state; an all-zero xorshift state would lock up.
    function automatic logic [31:0] chan_seed(input logic [31:0] base, input int k);
        logic [31:0] mix;
        logic [31:0] s;
        mix = 32'h9E3779B9 * 32'(k + 1);
        s   = base ^ mix;
        if (s == 32'h0) begin
            s = 32'h1;
        end else begin
            s = s;
        end
        return s;
    endfunction

    function automatic logic [31:0] xorshift32(input logic [31:0] s_in);
        logic [31:0] s;
        s = s_in ^ (s_in << 13);
        s = s ^ (s >> 17);
        s = s ^ (s << 5);
        return s;
    endfunction

    // Full-precision signed multiply, arithmetic shift, symmetric clamp.
    function automatic logic [OUT_W-1:0] scale_sat(input logic signed [ACC_W-1:0] c,
                                                   input logic [GAIN_W-1:0]       g);
        logic signed [PROD_W-1:0] cx;
        logic signed [PROD_W-1:0] gx;
        logic signed [PROD_W-1:0] p;
        logic [OUT_W-1:0]         r;
        cx = PROD_W'(c);
        gx = $signed(PROD_W'(g));
        p  = (cx * gx) >>> GAIN_FRAC;
        if (p > P_MAX) begin
            r = P_MAX[OUT_W-1:0];
        end else if (p < P_MIN) begin
            r = P_MIN[OUT_W-1:0];
        end else begin
            r = p[OUT_W-1:0];
        end
        return r;
    endfunction

    logic [31:0]              state_r [NUM_CH];
    logic [ACC_W-1:0]         acc_r   [NUM_CH];
    logic signed [ACC_W-1:0]  c_r     [NUM_CH];
    logic [GAIN_W-1:0]        gain_r  [NUM_CH];
    logic [CNT_W-1:0]         cnt_r;
    logic                     v1_r;
    logic                     x_en_r;
    logic [NUM_CH*OUT_W-1:0]  awgn_r;

    logic [31:0]              draw_s   [NUM_CH];
    logic [ACC_W-1:0]         sum_s    [NUM_CH];
    logic [OUT_W-1:0]         shaped_s [NUM_CH];

    // Next URNG state, running sum including this draw, and scaled stage-2 value.
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            draw_s[k]   = xorshift32(state_r[k]);
            sum_s[k]    = acc_r[k] + ACC_W'(draw_s[k][31 -: U_W]);
            shaped_s[k] = scale_sat(c_r[k], gain_r[k]);
        end
    end

    // URNG states, accumulators, draw counter and stage-1 capture.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                state_r[k] <= chan_seed(SEED_DEFAULT, k);
                acc_r[k]   <= '0;
                c_r[k]     <= '0;
            end
            cnt_r <= '0;
            v1_r  <= 1'b0;
        end else if (init) begin
            // A capture coinciding with init is dropped along with the sum.
            for (int k = 0; k < NUM_CH; k++) begin
                state_r[k] <= chan_seed(seed, k);
                acc_r[k]   <= '0;
            end
            cnt_r <= '0;
            v1_r  <= 1'b0;
        end else if (ce) begin
            for (int k = 0; k < NUM_CH; k++) begin
                state_r[k] <= draw_s[k];
            end
            if (cnt_r == CNT_LAST) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    // Centre the sum; leaves a fixed -SUM_LEN/2 LSB bias.
                    c_r[k]   <= $signed(sum_s[k] - OFFSET);
                    acc_r[k] <= '0;
                end
                cnt_r <= '0;
                v1_r  <= 1'b1;
            end else begin
                for (int k = 0; k < NUM_CH; k++) begin
                    acc_r[k] <= sum_s[k];
                end
                cnt_r <= cnt_r + CNT_W'(1);
                v1_r  <= 1'b0;
            end
        end else begin
            v1_r <= 1'b0;
        end
    end

    // Gain registers; writes are independent of ce and init.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                gain_r[k] <= GAIN_ONE;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (gain_we && (gain_sel == SEL_W'(k))) begin
                    gain_r[k] <= gain_val;
                end else begin
                    gain_r[k] <= gain_r[k];
                end
            end
        end
    end

    // Stage 2: register scaled samples; not gated by ce or init.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            awgn_r <= '0;
            x_en_r <= 1'b0;
        end else begin
            x_en_r <= v1_r;
            if (v1_r) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    awgn_r[k*OUT_W +: OUT_W] <= shaped_s[k];
                end
            end else begin
                awgn_r <= awgn_r;
            end
        end
    end

    assign x_en = x_en_r;
    assign awgn = awgn_r;

endmodule

// File: tb/tb_awgn_clt_gen.sv
// tb_awgn_clt_gen
// Directed bench for awgn_clt_gen at default parameters. Expected samples come
// from a sample-level reference (xorshift32 + sum + gain/clamp) kept in the bench.
module tb_awgn_clt_gen;

    localparam int NUM_CH = 2;
    localparam int OUT_W  = 16;

    logic                    clock    = 1'b0;
    logic                    rst_n    = 1'b0;
    logic                    init     = 1'b0;
    logic                    ce       = 1'b0;
    logic [31:0]             seed     = 32'h0;
    logic                    gain_we  = 1'b0;
    logic [0:0]              gain_sel = 1'b0;
    logic [15:0]             gain_val = 16'h0;
    logic                    x_en;
    logic [NUM_CH*OUT_W-1:0] awgn;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] ms [NUM_CH];
    int          mg [NUM_CH];
    int          exp_v [NUM_CH];
    int          hist [4][NUM_CH];

    awgn_clt_gen #(
        .NUM_CH(2), .OUT_W(16), .U_W(12), .SUM_LEN(12),
        .GAIN_W(16), .GAIN_FRAC(12), .SEED_DEFAULT(32'h1)
    ) dut (
        .clock(clock), .rst_n(rst_n), .init(init), .ce(ce), .seed(seed),
        .gain_we(gain_we), .gain_sel(gain_sel), .gain_val(gain_val),
        .x_en(x_en), .awgn(awgn)
    );

    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_step(input logic [31:0] s_in);
        logic [31:0] s;
        s = s_in;
        s = s ^ (s << 13);
        s = s ^ (s >> 17);
        s = s ^ (s << 5);
        return s;
    endfunction

    task automatic m_init(input logic [31:0] base);
        logic [31:0] v;
        for (int k = 0; k < NUM_CH; k++) begin
            v = base ^ (32'h9E3779B9 * (k + 1));
            if (v == 32'h0) v = 32'h1;
            ms[k] = v;
        end
    endtask

    function automatic int m_scale(input int c, input int g);
        longint p;
        p = longint'(c) * longint'(g);
        p = p >>> 12;
        if (p > 32767) p = 32767;
        else if (p < -32767) p = -32767;
        return int'(p);
    endfunction

    task automatic m_next();
        int sum;
        for (int k = 0; k < NUM_CH; k++) begin
            sum = 0;
            for (int i = 0; i < 12; i++) begin
                ms[k] = m_step(ms[k]);
                sum += int'(ms[k][31:20]);
            end
            exp_v[k] = m_scale(sum - 24576, mg[k]);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic int ch_val(input int k);
        return int'($signed(awgn[k*OUT_W +: OUT_W]));
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_pulse(output int t, output bit f);
        t = 0;
        f = 1'b0;
        while (!f && t < 40) begin
            tick();
            t++;
            f = (x_en === 1'b1);
        end
    endtask

    task automatic do_init(input logic [31:0] s);
        seed = s;
        init = 1'b1;
        tick();
        init = 1'b0;
        m_init(s);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int t; bit f;
        ce = 1'b0;
        repeat (2) tick();
        n_cmp++; if (x_en !== 1'b0) $display("FAIL reset_x_en: got %b want 0", x_en);
        if (x_en !== 1'b0) n_bad++;
        n_cmp++; if (awgn !== 32'h0) begin n_bad++; $display("FAIL reset_awgn: got %h want 0", awgn); end
        rst_n = 1'b1;
        m_init(32'h1);
        mg[0] = 4096; mg[1] = 4096;
        ce = 1'b1;
        wait_pulse(t, f);
        n_cmp++; if (!f || t != 13) begin n_bad++; $display("FAIL reset_first_latency: got %0d want 13", t); end
        m_next();
        for (int k = 0; k < NUM_CH; k++) begin
            n_cmp++; if (ch_val(k) != exp_v[k]) begin n_bad++; $display("FAIL reset_sample ch%0d: got %0d want %0d", k, ch_val(k), exp_v[k]); end
        end
        ce = 1'b0;
    endtask

    task automatic test_determinism();
        int t; bit f;
        for (int run = 0; run < 2; run++) begin
            ce = 1'b0;
            do_init(32'd321675456);
            ce = 1'b1;
            for (int s = 0; s < 4; s++) begin
                wait_pulse(t, f);
                n_cmp++; if (!f || t != ((s == 0) ? 13 : 12)) begin n_bad++; $display("FAIL det_period run%0d s%0d: got %0d want %0d", run, s, t, (s == 0) ? 13 : 12); end
                if (run == 0) begin
                    m_next();
                    for (int k = 0; k < NUM_CH; k++) hist[s][k] = exp_v[k];
                end
                for (int k = 0; k < NUM_CH; k++) begin
                    n_cmp++; if (ch_val(k) != hist[s][k]) begin n_bad++; $display("FAIL det_sample run%0d s%0d ch%0d: got %0d want %0d", run, s, k, ch_val(k), hist[s][k]); end
                end
            end
        end
        ce = 1'b0;
    endtask

    task automatic test_zero_seed();
        int t; bit f;
        // Channel 0 seed collapses to zero and must load 1 instead.
        ce = 1'b0;
        do_init(32'h9E3779B9);
        ce = 1'b1;
        for (int s = 0; s < 2; s++) begin
            wait_pulse(t, f);
            m_next();
            n_cmp++; if (!f) begin n_bad++; $display("FAIL zero_seed_pulse s%0d: got none want pulse", s); end
            for (int k = 0; k < NUM_CH; k++) begin
                n_cmp++; if (ch_val(k) != exp_v[k]) begin n_bad++; $display("FAIL zero_seed s%0d ch%0d: got %0d want %0d", s, k, ch_val(k), exp_v[k]); end
            end
        end
        ce = 1'b0;
    endtask

    task automatic test_ce_stall();
        bit pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        int highs; int samples; int i; bit cur;
        ce = 1'b0;
        do_init(32'hDEADBEEF);
        highs = 0; samples = 0; i = 0;
        while (samples < 3 && i < 300) begin
            ce = pat[i % 5];
            cur = pat[i % 5];
            tick();
            i++;
            if (x_en === 1'b1) begin
                n_cmp++; if (highs != 12) begin n_bad++; $display("FAIL stall_ce_count s%0d: got %0d want 12", samples, highs); end
                m_next();
                for (int k = 0; k < NUM_CH; k++) begin
                    n_cmp++; if (ch_val(k) != exp_v[k]) begin n_bad++; $display("FAIL stall_sample s%0d ch%0d: got %0d want %0d", samples, k, ch_val(k), exp_v[k]); end
                end
                samples++;
                highs = int'(cur);
            end else begin
                highs += int'(cur);
            end
        end
        n_cmp++; if (samples != 3) begin n_bad++; $display("FAIL stall_timeout: got %0d want 3", samples); end
        ce = 1'b0;
    endtask

    task automatic test_init_mid();
        int t; bit f;
        ce = 1'b0;
        do_init(32'h12345678);
        ce = 1'b1;
        repeat (7) tick();
        do_init(32'h12345678);          // ce stays high; init wins
        wait_pulse(t, f);
        n_cmp++; if (!f || t != 13) begin n_bad++; $display("FAIL init_mid_latency: got %0d want 13", t); end
        m_next();
        for (int k = 0; k < NUM_CH; k++) begin
            n_cmp++; if (ch_val(k) != exp_v[k]) begin n_bad++; $display("FAIL init_mid_sample ch%0d: got %0d want %0d", k, ch_val(k), exp_v[k]); end
        end
        // init on the capture cycle: sample dropped, awgn holds.
        repeat (10) tick();
        do_init(32'h12345678);
        tick();
        n_cmp++; if (x_en !== 1'b0) begin n_bad++; $display("FAIL init_capture_x_en: got %b want 0", x_en); end
        n_cmp++; if (ch_val(0) != exp_v[0]) begin n_bad++; $display("FAIL init_capture_hold: got %0d want %0d", ch_val(0), exp_v[0]); end
        wait_pulse(t, f);
        n_cmp++; if (!f || t != 12) begin n_bad++; $display("FAIL init_capture_restart: got %0d want 12", t); end
        m_next();
        for (int k = 0; k < NUM_CH; k++) begin
            n_cmp++; if (ch_val(k) != exp_v[k]) begin n_bad++; $display("FAIL init_capture_sample ch%0d: got %0d want %0d", k, ch_val(k), exp_v[k]); end
        end
        // init during stage 2: that pulse still emerges.
        repeat (11) tick();
        m_next();
        do_init(32'h12345678);
        n_cmp++; if (x_en !== 1'b1) begin n_bad++; $display("FAIL init_stage2_x_en: got %b want 1", x_en); end
        n_cmp++; if (ch_val(1) != exp_v[1]) begin n_bad++; $display("FAIL init_stage2_sample: got %0d want %0d", ch_val(1), exp_v[1]); end
        wait_pulse(t, f);
        n_cmp++; if (!f || t != 13) begin n_bad++; $display("FAIL init_stage2_restart: got %0d want 13", t); end
        m_next();
        n_cmp++; if (ch_val(0) != exp_v[0]) begin n_bad++; $display("FAIL init_stage2_next: got %0d want %0d", ch_val(0), exp_v[0]); end
        ce = 1'b0;
    endtask

    task automatic test_gain_timing();
        int t; bit f;
        ce = 1'b0;
        do_init(32'hCAFEF00D);
        ce = 1'b1;
        repeat (12) tick();
        n_cmp++; if (x_en !== 1'b0) begin n_bad++; $display("FAIL gt_early_x_en: got %b want 0", x_en); end
        // Stage-2 cycle: the coincident gain write must not affect this sample.
        ce = 1'b0;
        gain_we = 1'b1; gain_sel = 1'b0; gain_val = 16'd8192;
        tick();
        gain_we = 1'b0;
        m_next();
        n_cmp++; if (x_en !== 1'b1) begin n_bad++; $display("FAIL gt_x_en: got %b want 1", x_en); end
        n_cmp++; if (ch_val(0) != exp_v[0]) begin n_bad++; $display("FAIL gt_old_gain: got %0d want %0d", ch_val(0), exp_v[0]); end
        mg[0] = 8192;
        ce = 1'b1;
        wait_pulse(t, f);
        m_next();
        n_cmp++; if (!f || t != 13) begin n_bad++; $display("FAIL gt_latency: got %0d want 13", t); end
        for (int k = 0; k < NUM_CH; k++) begin
            n_cmp++; if (ch_val(k) != exp_v[k]) begin n_bad++; $display("FAIL gt_new_gain ch%0d: got %0d want %0d", k, ch_val(k), exp_v[k]); end
        end
        ce = 1'b0;
    endtask

    task automatic test_gain_sat();
        int t; bit f;
        ce = 1'b0;
        gain_we = 1'b1; gain_sel = 1'b0; gain_val = 16'h0000;
        tick();
        gain_sel = 1'b1; gain_val = 16'hFFFF;
        tick();
        gain_we = 1'b0;
        mg[0] = 0; mg[1] = 65535;
        do_init(32'd321675456);
        ce = 1'b1;
        for (int s = 0; s < 8; s++) begin
            wait_pulse(t, f);
            m_next();
            n_cmp++; if (!f || ch_val(0) != 0) begin n_bad++; $display("FAIL sat_ch0_zero s%0d: got %0d want 0", s, ch_val(0)); end
            n_cmp++; if (ch_val(1) != exp_v[1]) begin n_bad++; $display("FAIL sat_ch1 s%0d: got %0d want %0d", s, ch_val(1), exp_v[1]); end
        end
    endtask

    task automatic test_reset_mid();
        int t; bit f;
        ce = 1'b1;
        repeat (5) tick();
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (x_en !== 1'b0) begin n_bad++; $display("FAIL midreset_x_en: got %b want 0", x_en); end
        n_cmp++; if (awgn !== 32'h0) begin n_bad++; $display("FAIL midreset_awgn: got %h want 0", awgn); end
        tick();
        rst_n = 1'b1;
        m_init(32'h1);
        mg[0] = 4096; mg[1] = 4096;
        wait_pulse(t, f);
        m_next();
        n_cmp++; if (!f || t != 13) begin n_bad++; $display("FAIL midreset_latency: got %0d want 13", t); end
        for (int k = 0; k < NUM_CH; k++) begin
            n_cmp++; if (ch_val(k) != exp_v[k]) begin n_bad++; $display("FAIL midreset_gain_one ch%0d: got %0d want %0d", k, ch_val(k), exp_v[k]); end
        end
        ce = 1'b0;
    endtask

    initial begin
        test_reset();
        test_determinism();
        test_zero_seed();
        test_ce_stall();
        test_init_mid();
        test_gain_timing();
        test_gain_sat();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
